div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//   Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions.
//   Sits directly downstream of the decoder and is launched by its div_start/div_op.
//   Stalls the core through div_busy. Returns the quotient or remainder, with its rd tag,
//   on a one-cycle div_done pulse.
// PARAMETERS
//   XLEN     32   operand/result width (only 32 is verified)
//   CNT_W    6    iteration counter width; must hold XLEN
// PORTS
//   clk          in   1     single clock; all state updates on rising edge
//   rst_n        in   1     reset, asynchronous, active-low
//   div_start    in   1     decoder request; sampled only when idle
//   div_op       in   3     100 DIV, 101 DIVU, 110 REM, 111 REMU
//   div_kill     in   1     pipeline flush; aborts the operation in flight
//   rs1_val      in   XLEN  dividend
//   rs2_val      in   XLEN  divisor
//   rd_in        in   5     destination register tag
//   div_busy     out  1     high while state != IDLE
//   div_done     out  1     one-cycle pulse; result and tag valid
//   div_result   out  XLEN  quotient or remainder; held until next accept
//   div_rd       out  5     tag captured at accept
// BEHAVIOUR
//   Reset: state=IDLE. div_busy, div_done, div_result, div_rd and all internal regs are 0.
//   Accept:
//     - edge where state==IDLE && div_start && div_op[2] && !div_kill.
//     - Latches op, operands, rd_in and the signed/rem flags.
//     - div_start when busy, or with div_op[2]==0, is ignored (no queueing).
//   FSM IDLE -> CALC -> DONE -> IDLE:
//     - IDLE->CALC on a normal accept. count=0. remainder reg=0.
//       Quotient reg = |dividend| (signed ops) or raw dividend (unsigned ops).
//     - CALC, one iteration per cycle:
//       {R,Q} <<= 1; if R >= |divisor| then R -= |divisor|, Q[0] = 1.
//       R is XLEN+1 bits so the compare never overflows.
//     - After XLEN CALC cycles -> DONE.
//     - DONE lasts one cycle: div_done=1, div_result/div_rd valid. Next edge -> IDLE.
//   Latency, normal case: accept at edge E0; div_done high in the cycle after edge E0+XLEN+1
//     (33 cycles). div_busy high from E0 through the done cycle inclusive.
//   Special cases go IDLE->DONE directly (done in the cycle after E0):
//     - divisor==0: DIV/DIVU -> all ones; REM/REMU -> dividend.
//     - DIV/REM with dividend 0x80000000 and divisor all ones: DIV -> 0x80000000, REM -> 0.
//   Sign fix-up, applied when entering DONE (signed ops only):
//     - quotient negated if the operand signs differ;
//     - remainder takes the sign of the dividend (negated if the dividend is negative).
//   Result select: op[1]=0 -> quotient; op[1]=1 -> remainder.
//   div_kill:
//     - in CALC or DONE: next state IDLE, div_done forced 0 that cycle, div_result unchanged.
//     - in IDLE: blocks an accept in the same cycle.
//   Reset mid-operation: immediate return to IDLE with all outputs 0. No done is produced.
//   No combinational path from inputs to outputs.
// TESTING
//   Quotient/remainder:
//     - DIV 20/3 -> 6; REM 20/3 -> 2; done exactly 33 cycles after accept.
//     - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REMU 7/0xFFFFFFFE -> 7.
//   Unsigned: DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF; REMU -> 1; signed result not applied.
//   Special cases:
//     - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000.
//     - Each with div_done one cycle after accept.
//   Busy handling: second div_start at cycle 10 of an operation -> ignored.
//     - First result and rd are unaffected.
//     - A new accept is possible only in the cycle after done.
//   Abort:
//     - div_kill at cycle 15 -> IDLE next cycle, no done pulse; div_result keeps the prior value.
//     - rst_n low mid-CALC -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Latency: div_done in the cycle after edge E0+XLEN+1 (33 cycles); div-by-zero/overflow after E0.
// Backpressure: none queued; div_start is only sampled while idle, div_busy stalls the core.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   div_start      decoder request, accepted only in IDLE with div_op[2]=1 and no div_kill
//   div_op[2:0]    100 DIV, 101 DIVU, 110 REM, 111 REMU
//   div_kill       pipeline flush; aborts the operation in flight / blocks an accept
//   rs1_val        dividend
//   rs2_val        divisor
//   rd_in          destination register tag
//   div_busy       high from the accept edge through the done cycle
//   div_done       one-cycle pulse, div_result/div_rd valid
//   div_result     quotient or remainder, held until the next result
//   div_rd         tag captured at accept
// All outputs come straight from flops.
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_start,
  input  logic [2:0]      div_op,
  input  logic            div_kill,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            div_busy,
  output logic            div_done,
  output logic [XLEN-1:0] div_result,
  output logic [4:0]      div_rd
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  // State registers
  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0] rem_q, rem_d;     // partial remainder (always < divisor between steps)
  logic [XLEN-1:0] quo_q, quo_d;     // dividend shifting out, quotient shifting in
  logic [XLEN-1:0] dvsr_q, dvsr_d;   // |divisor|
  logic            is_rem_q, is_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [4:0]      rd_q, rd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  // Combinational helpers
  logic            accept;
  logic            op_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN:0]   rem_shift;        // one bit wider so the compare cannot overflow
  logic [XLEN-1:0] quo_shift;
  logic [XLEN-1:0] quo_fix, rem_fix;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rd_d      = rd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;

    accept    = (state_q == ST_IDLE) && div_start && div_op[2] && !div_kill;
    op_signed = ~div_op[0];
    a_neg     = op_signed & rs1_val[XLEN-1];
    b_neg     = op_signed & rs2_val[XLEN-1];
    a_abs     = a_neg ? (~rs1_val + 1'b1) : rs1_val;
    b_abs     = b_neg ? (~rs2_val + 1'b1) : rs2_val;
    div_zero  = (rs2_val == '0);
    div_ovf   = op_signed && (rs1_val == INT_MIN) && (rs2_val == '1);

    // One restoring step: shift {R,Q} left, subtract the divisor when it fits.
    rem_shift = {rem_q, quo_q[XLEN-1]};
    quo_shift = {quo_q[XLEN-2:0], 1'b0};

    // Sign fix-up of the finished magnitudes.
    quo_fix   = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix   = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rd_d     = rd_in;
          is_rem_d = div_op[1];
          busy_d   = 1'b1;
          if (div_zero) begin
            // x/0: quotient all ones, remainder is the dividend
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = div_op[1] ? rs1_val : '1;
          end else if (div_ovf) begin
            // INT_MIN / -1: quotient wraps to INT_MIN, remainder 0
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = div_op[1] ? '0 : rs1_val;
          end else begin
            state_d   = ST_CALC;
            count_d   = '0;
            rem_d     = '0;
            quo_d     = a_abs;
            dvsr_d    = b_abs;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
          end
        end
      end

      ST_CALC: begin
        if (div_kill) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (count_q == CNT_LAST) begin
          // All quotient bits are in; register the signed result.
          state_d  = ST_DONE;
          done_d   = 1'b1;
          result_d = is_rem_q ? rem_fix : quo_fix;
        end else begin
          count_d = count_q + 1'b1;
          if (rem_shift >= {1'b0, dvsr_q}) begin
            // The difference is below the divisor, so the low XLEN bits hold it exactly.
            rem_d = rem_shift[XLEN-1:0] - dvsr_q;
            quo_d = {quo_shift[XLEN-1:1], 1'b1};
          end else begin
            rem_d = rem_shift[XLEN-1:0];
            quo_d = quo_shift;
          end
        end
      end

      ST_DONE: begin
        // The done pulse lasts exactly this cycle; a kill here changes nothing further.
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rd_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rd_q      <= rd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign div_busy   = busy_q;
  assign div_done   = done_q;
  assign div_result = result_q;
  assign div_rd     = rd_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed RV32M cases, busy/kill/reset handling and random
// operations compared against an arithmetic reference model.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        div_start;
  logic [2:0]  div_op;
  logic        div_kill;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_in;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_result;
  logic [4:0]  div_rd;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_result = 32'h0;

  div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_start  (div_start),
    .div_op     (div_op),
    .div_kill   (div_kill),
    .rs1_val    (rs1_val),
    .rs2_val    (rs2_val),
    .rd_in      (rd_in),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .div_result (div_result),
    .div_rd     (div_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RV32M semantics written directly from the instruction definitions.
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int signed sa;
    int signed sb;
    logic [31:0] r;
    sa = a;
    sb = b;
    if (b == 32'h0)
      r = op[1] ? a : 32'hFFFF_FFFF;
    else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      r = op[1] ? 32'h0 : 32'h8000_0000;
    else if (!op[0])
      r = op[1] ? sa % sb : sa / sb;
    else
      r = op[1] ? a % b : a / b;
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (b == 32'h0) return 0;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 33;
  endfunction

  // Present a request for one edge; returns #1 after the accept edge with operands scrambled.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    @(negedge clk);
    div_start = 1'b1;
    div_op    = op;
    rs1_val   = a;
    rs2_val   = b;
    rd_in     = rd;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    rs1_val   = $urandom;
    rs2_val   = $urandom;
    rd_in     = 5'($urandom);
  endtask

  // Counts edges (after the current sample point) until div_done, bounded.
  task automatic wait_done(output int k, output bit got);
    k   = 0;
    got = div_done;
    while (!got && k < 60) begin
      @(posedge clk);
      #1;
      k++;
      got = div_done;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int k;
    bit got;
    launch(op, a, b, rd);
    chk({tag, " busy"}, div_busy, 1'b1);
    wait_done(k, got);
    chk({tag, " done_seen"}, got, 1'b1);
    chk({tag, " latency"}, k, ref_lat(op, a, b));
    chk({tag, " result"}, div_result, exp);
    chk({tag, " rd"}, div_rd, rd);
    chk({tag, " busy_in_done"}, div_busy, 1'b1);
    last_result = exp;
    @(posedge clk);
    #1;
    chk({tag, " done_pulse"}, div_done, 1'b0);
    chk({tag, " idle"}, div_busy, 1'b0);
  endtask

  initial begin
    int k;
    bit got;
    int ndone;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    rst_n     = 1'b0;
    div_start = 1'b0;
    div_op    = 3'b000;
    div_kill  = 1'b0;
    rs1_val   = 32'h0;
    rs2_val   = 32'h0;
    rd_in     = 5'h0;

    // Reset state
    #12;
    chk("rst busy", div_busy, 1'b0);
    chk("rst done", div_done, 1'b0);
    chk("rst result", div_result, 32'h0);
    chk("rst rd", div_rd, 5'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic
    run_op("div20_3",    3'b100, 32'd20,         32'd3,          5'd1,  32'd6);
    run_op("rem20_3",    3'b110, 32'd20,         32'd3,          5'd2,  32'd2);
    run_op("div-7_2",    3'b100, 32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD);
    run_op("rem-7_2",    3'b110, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFF);
    run_op("remu7_big",  3'b111, 32'd7,          32'hFFFF_FFFE,  5'd5,  32'd7);
    run_op("divu_max_2", 3'b101, 32'hFFFF_FFFF,  32'd2,          5'd6,  32'h7FFF_FFFF);
    run_op("remu_max_2", 3'b111, 32'hFFFF_FFFF,  32'd2,          5'd7,  32'd1);
    run_op("div5_0",     3'b100, 32'd5,          32'd0,          5'd8,  32'hFFFF_FFFF);
    run_op("rem5_0",     3'b110, 32'd5,          32'd0,          5'd9,  32'd5);
    run_op("div_ovf",    3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'h8000_0000);
    run_op("rem_ovf",    3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'h0);

    // Start while busy is ignored; accept only in the cycle after done
    launch(3'b100, 32'd1000, 32'd7, 5'd9);
    repeat (9) @(posedge clk);
    @(negedge clk);
    div_start = 1'b1;
    div_op    = 3'b101;
    rs1_val   = 32'd5;
    rs2_val   = 32'd1;
    rd_in     = 5'd22;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    wait_done(k, got);
    chk("busy done_seen", got, 1'b1);
    chk("busy result", div_result, 32'd142);
    chk("busy rd", div_rd, 5'd9);
    div_start = 1'b1;
    div_op    = 3'b110;
    rs1_val   = 32'd1000;
    rs2_val   = 32'd7;
    rd_in     = 5'd3;
    @(posedge clk);
    #1;
    chk("start_in_done ignored", div_busy, 1'b0);
    chk("start_in_done no_done", div_done, 1'b0);
    @(posedge clk);
    #1;
    div_start = 1'b0;
    chk("accept_after_done", div_busy, 1'b1);
    wait_done(k, got);
    chk("second done_seen", got, 1'b1);
    chk("second latency", k, 33);
    chk("second result", div_result, 32'd6);
    chk("second rd", div_rd, 5'd3);
    last_result = 32'd6;
    @(posedge clk);
    #1;

    // Kill mid-CALC
    launch(3'b100, 32'd100, 32'd7, 5'd4);
    repeat (14) @(posedge clk);
    @(negedge clk);
    div_kill = 1'b1;
    @(posedge clk);
    #1;
    div_kill = 1'b0;
    chk("kill busy", div_busy, 1'b0);
    chk("kill done", div_done, 1'b0);
    chk("kill result_held", div_result, last_result);
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (div_done) ndone++;
    end
    chk("kill no_done", ndone, 0);

    // Kill in IDLE blocks the accept
    @(negedge clk);
    div_start = 1'b1;
    div_kill  = 1'b1;
    div_op    = 3'b100;
    rs1_val   = 32'd9;
    rs2_val   = 32'd0;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    div_kill  = 1'b0;
    chk("kill_idle busy", div_busy, 1'b0);
    chk("kill_idle done", div_done, 1'b0);

    // Asynchronous reset mid-CALC
    launch(3'b101, 32'd12345, 32'd11, 5'd7);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst busy", div_busy, 1'b0);
    chk("arst done", div_done, 1'b0);
    chk("arst result", div_result, 32'h0);
    chk("arst rd", div_rd, 5'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (div_done) ndone++;
    end
    chk("arst no_done", ndone, 0);
    run_op("after_rst", 3'b100, 32'd20, 32'd3, 5'd12, 32'd6);

    // Random operations against the reference model
    for (int i = 0; i < 24; i++) begin
      op = {1'b1, 2'($urandom)};
      case ($urandom_range(0, 5))
        0: begin a = $urandom; b = 32'h0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
        3: begin a = $urandom; b = $urandom_range(1, 16); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      run_op("rand", op, a, b, 5'($urandom), ref_div(op, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
